// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the F/D pipeline register payload.
package y86_pkg;

    localparam int unsigned IBYTES = 10;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [1:0] {
        S_AOK = 2'd0,
        S_HLT = 2'd1,
        S_ADR = 2'd2,
        S_INS = 2'd3
    } stat_e;

    // Non-datapath part of the D register; valC/valP travel alongside at PC_W.
    typedef struct packed {
        stat_e      stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       valid;
    } d_ctl_t;

    localparam d_ctl_t D_CTL_BUBBLE = '{
        stat:  S_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        valid: 1'b0
    };

endpackage

// File: rtl/y86_instr_split.sv
// Combinational Y86-64 instruction splitter: length, register ids and constant.
module y86_instr_split
    import y86_pkg::*;
#(
    parameter int unsigned PC_W = 64
) (
    input  logic [IBYTES-1:0][7:0] ibytes,
    output logic [3:0]             icode,
    output logic [3:0]             ifun,
    output logic [3:0]             ra,
    output logic [3:0]             rb,
    output logic [PC_W-1:0]        valc,
    output logic [3:0]             length,
    output logic                   need_regids,
    output logic                   need_valc,
    output logic                   instr_invalid
);

    logic [63:0] valc_raw;

    always_comb begin
        icode         = ibytes[0][7:4];
        ifun          = ibytes[0][3:0];
        need_regids   = 1'b0;
        need_valc     = 1'b0;
        instr_invalid = 1'b0;

        case (icode)
            I_HALT, I_NOP, I_RET: ;
            I_RRMOVQ: begin
                need_regids   = 1'b1;
                instr_invalid = (ifun > 4'd6);
            end
            I_OPQ: begin
                need_regids   = 1'b1;
                instr_invalid = (ifun > 4'd3);
            end
            I_PUSHQ, I_POPQ: need_regids = 1'b1;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
            end
            I_JXX: begin
                need_valc     = 1'b1;
                instr_invalid = (ifun > 4'd6);
            end
            I_CALL:  need_valc = 1'b1;
            default: instr_invalid = 1'b1;
        endcase

        // Illegal encodings are one byte long with no operand fields.
        if (instr_invalid) begin
            need_regids = 1'b0;
            need_valc   = 1'b0;
        end

        ra       = need_regids ? ibytes[1][7:4] : RNONE;
        rb       = need_regids ? ibytes[1][3:0] : RNONE;
        valc_raw = need_regids ? ibytes[9:2] : ibytes[8:1];
        valc     = need_valc ? PC_W'(valc_raw) : '0;
        length   = 4'd1 + {3'b000, need_regids} + (need_valc ? 4'd8 : 4'd0);
    end

endmodule

// File: rtl/y86_fetch_pipe.sv
// Y86-64 fetch stage: PC, byte imem, decode/prediction and the F/D register.
module y86_fetch_pipe
    import y86_pkg::*;
#(
    parameter int unsigned     IMEM_BYTES = 512,
    parameter int unsigned     PC_W       = 64,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    localparam int unsigned    AW         = $clog2(IMEM_BYTES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            imem_we,
    input  logic [AW-1:0]   imem_waddr,
    input  logic [7:0]      imem_wdata,
    input  logic            f_stall,
    input  logic            d_stall,
    input  logic            d_bubble,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] f_pc,
    output logic [1:0]      D_stat,
    output logic [3:0]      D_icode,
    output logic [3:0]      D_ifun,
    output logic [3:0]      D_rA,
    output logic [3:0]      D_rB,
    output logic [PC_W-1:0] D_valC,
    output logic [PC_W-1:0] D_valP,
    output logic            D_valid
);

    localparam int unsigned EW = PC_W + 1;

    logic [7:0]             imem_q [IMEM_BYTES];
    logic [PC_W-1:0]        f_pc_q,   f_pc_d;
    logic                   halted_q, halted_d;
    d_ctl_t                 d_ctl_q,  d_ctl_d;
    logic [PC_W-1:0]        d_valc_q, d_valc_d;
    logic [PC_W-1:0]        d_valp_q, d_valp_d;

    logic [EW-1:0]          byte_addr [IBYTES];
    logic [IBYTES-1:0]      in_range;
    logic [IBYTES-1:0][7:0] fbytes;

    logic [3:0]             f_icode, f_ifun, f_ra, f_rb, f_len;
    logic [PC_W-1:0]        f_valc, f_valp, pred_pc;
    logic                   f_need_regids, f_need_valc, f_invalid, f_adr;
    stat_e                  f_stat;

    // Program load port; a same-cycle fetch of the written byte sees old data.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem_q[imem_waddr] <= imem_wdata;
        end
    end

    // Extended-width byte addresses so an instruction running past the top is caught.
    always_comb begin
        for (int unsigned k = 0; k < IBYTES; k++) begin
            byte_addr[k] = {1'b0, f_pc_q} + EW'(k);
            in_range[k]  = (byte_addr[k] < EW'(IMEM_BYTES));
            fbytes[k]    = in_range[k] ? imem_q[AW'(byte_addr[k])] : 8'h00;
        end
    end

    y86_instr_split #(
        .PC_W (PC_W)
    ) u_split (
        .ibytes        (fbytes),
        .icode         (f_icode),
        .ifun          (f_ifun),
        .ra            (f_ra),
        .rb            (f_rb),
        .valc          (f_valc),
        .length        (f_len),
        .need_regids   (f_need_regids),
        .need_valc     (f_need_valc),
        .instr_invalid (f_invalid)
    );

    // Status, fall-through and prediction; jxx/call are the constant-only forms.
    always_comb begin
        f_adr = 1'b0;
        for (int unsigned k = 0; k < IBYTES; k++) begin
            if ((4'(k) < f_len) && !in_range[k]) begin
                f_adr = 1'b1;
            end
        end

        if (f_adr) begin
            f_stat = S_ADR;
        end else if (f_invalid) begin
            f_stat = S_INS;
        end else if (f_icode == I_HALT) begin
            f_stat = S_HLT;
        end else begin
            f_stat = S_AOK;
        end

        f_valp  = f_pc_q + PC_W'(f_len);
        pred_pc = (f_need_valc && !f_need_regids) ? f_valc : f_valp;
    end

    // Per-edge priority: redirect, halted, then normal fetch with stall/bubble.
    always_comb begin
        f_pc_d   = f_pc_q;
        halted_d = halted_q;
        d_ctl_d  = d_ctl_q;
        d_valc_d = d_valc_q;
        d_valp_d = d_valp_q;

        if (redirect_valid) begin
            f_pc_d   = redirect_pc;
            halted_d = 1'b0;
            d_ctl_d  = D_CTL_BUBBLE;
            d_valc_d = '0;
            d_valp_d = '0;
        end else if (halted_q) begin
            d_ctl_d  = D_CTL_BUBBLE;
            d_valc_d = '0;
            d_valp_d = '0;
        end else begin
            if (!f_stall) begin
                f_pc_d = pred_pc;
            end

            if (d_bubble || (f_stall && !d_stall)) begin
                d_ctl_d  = D_CTL_BUBBLE;
                d_valc_d = '0;
                d_valp_d = '0;
            end else if (!d_stall) begin
                d_ctl_d  = '{stat: f_stat, icode: f_icode, ifun: f_ifun,
                             ra: f_ra, rb: f_rb, valid: 1'b1};
                d_valc_d = f_valc;
                d_valp_d = f_valp;
                halted_d = (f_stat != S_AOK);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_pc_q   <= RESET_PC;
            halted_q <= 1'b0;
            d_ctl_q  <= D_CTL_BUBBLE;
            d_valc_q <= '0;
            d_valp_q <= '0;
        end else begin
            f_pc_q   <= f_pc_d;
            halted_q <= halted_d;
            d_ctl_q  <= d_ctl_d;
            d_valc_q <= d_valc_d;
            d_valp_q <= d_valp_d;
        end
    end

    assign f_pc    = f_pc_q;
    assign D_stat  = d_ctl_q.stat;
    assign D_icode = d_ctl_q.icode;
    assign D_ifun  = d_ctl_q.ifun;
    assign D_rA    = d_ctl_q.ra;
    assign D_rB    = d_ctl_q.rb;
    assign D_valC  = d_valc_q;
    assign D_valP  = d_valp_q;
    assign D_valid = d_ctl_q.valid;

endmodule

// File: doc/y86_fetch_pipe.md
Name: y86_fetch_pipe

Overview:
- Parametrised, registered fetch stage for the pipelined Y86-64 core.
- Holds the fetch PC and a byte-addressed instruction memory, and decodes instruction length and fields.
- Predicts the next PC and drives the F/D pipeline register.
- Supports stall, bubble and redirect control from the hazard unit, and reports a per-instruction status (AOK/HLT/ADR/INS) in place of a bare valid bit.

Parameters:
- IMEM_BYTES, 512, instruction memory size in bytes.
- PC_W, 64, width of PC, valC and valP.
- RESET_PC, 0, fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_we  in  1  byte write enable for loading the program
- imem_waddr  in  $clog2(IMEM_BYTES)  write byte address
- imem_wdata  in  8  write byte
- f_stall  in  1  hold the fetch PC
- d_stall  in  1  hold the D register
- d_bubble  in  1  load a bubble into the D register
- redirect_valid  in  1  mispredict or ret correction
- redirect_pc  in  PC_W  corrected fetch address
- f_pc  out  PC_W  current fetch address (registered)
- D_stat  out  2  0=AOK 1=HLT 2=ADR 3=INS
- D_icode  out  4  instruction code
- D_ifun  out  4  function code
- D_rA  out  4  register A field
- D_rB  out  4  register B field
- D_valC  out  PC_W  constant field
- D_valP  out  PC_W  fall-through address
- D_valid  out  1  0 when the D register holds a bubble

Behaviour:
- Reset, synchronous: f_pc=RESET_PC; halted=0; D register = bubble. Imem contents are unaffected by reset.
- Bubble value: stat=AOK, icode=1 (nop), ifun=0, rA=rB=F, valC=0, valP=0, valid=0.
- Imem read: combinational, bytes f_pc..f_pc+9, byte 0 is first.
  - Byte 0 = {icode[7:4], ifun[3:0]}.
  - Byte 1 = {rA, rB}.
  - valC is little-endian.
- Imem write: one byte per cycle on the clock edge. A fetch of the same byte in the same cycle sees the old data.
- Instruction length by icode:
  - 0 halt, 1 nop, 9 ret: length 1.
  - 2 cmov, 6 OPq, A pushq, B popq: length 2.
  - 3 irmovq, 4 rmmovq, 5 mrmovq: length 10.
  - 7 jxx, 8 call: length 9.
- Field extraction:
  - Without regids: rA=rB=F.
  - valC comes from byte 2 when regids are present, else from byte 1.
  - valC=0 when the instruction has no constant.
- valP = f_pc + length, modulo 2^PC_W.
- Status:
  - INS: icode C–F, OPq ifun>3, or jxx/cmov ifun>6. Length is treated as 1.
  - ADR: any byte of the instruction at or beyond IMEM_BYTES. ADR takes priority over INS. Bytes out of range read as 0.
  - HLT: icode 0.
  - AOK: otherwise.
- Predicted PC: valC for jxx and call; valP otherwise.
- Latency: the instruction at f_pc appears on the D_ outputs after exactly one clock edge.
- Per-edge priority, evaluated in order:
  1. rst: as above.
  2. redirect_valid: f_pc<=redirect_pc, D<=bubble, halted<=0. Overrides f_stall, d_stall and d_bubble.
  3. halted=1: f_pc holds, D<=bubble.
  4. Fetch PC: f_pc<=predPC unless f_stall.
  5. D register, first match wins:
     - d_bubble -> bubble.
     - d_stall -> hold.
     - f_stall and not d_stall -> bubble. This is the ret wait; no duplicate fetch reaches D.
     - otherwise load the fetched fields, valid=1.
  6. halted<=1 when a non-AOK instruction is loaded into D.
- While halted, only redirect or reset resumes fetch. This lets a squashed wrong-path halt recover.
- PC arithmetic wraps at 2^PC_W. A valC beyond imem produces ADR on the next fetch, not an error at prediction time.

Decomposition:
- Package y86_pkg holds:
  - icode constants (I_HALT … I_POPQ).
  - stat constants (S_AOK, S_HLT, S_ADR, S_INS).
  - RNONE=4'hF.
  - The bubble constant for the D register struct.
- Natural sub-module: y86_instr_split. It is combinational: 10 bytes in, out icode, ifun, rA, rB, valC, length, need_regids, need_valC and instr_invalid. The decode stage can reuse it for checks.

Test Plan:
- Reset, then load 30 F2 0A 00 00 00 00 00 00 00 at 0 -> after first edge: D_icode=3, D_rB=2, D_valC=10, D_valP=10, D_stat=AOK, and f_pc=10.
- Load 70 20 00 00 00 00 00 00 00 at 0 (jmp 0x20) -> D_valP=9, D_valC=0x20; next f_pc=0x20, with D_rA=D_rB=F.
- Byte C0 at 0 -> D_stat=INS, D_valP=1. The following cycles give D_valid=0 and f_pc frozen until redirect_valid with redirect_pc=0x40, after which fetch resumes at 0x40.
- Place 30 F0 at IMEM_BYTES-2 and jump there -> D_stat=ADR.
- Assert f_stall=1, d_stall=0 for 2 cycles during straight-line nops -> two bubbles with f_pc unchanged; on release the instruction at the held f_pc loads.
- Assert f_stall, d_stall and redirect_valid together -> redirect wins, f_pc=redirect_pc and D is a bubble. Also assert rst mid-program -> f_pc=RESET_PC, D_valid=0, and imem contents are retained.
